// File: rtl/timer_regfile_mc.sv
// Timer register file with NUM_CH compare channels.
// Holds the control, counter-load, compare/period, interrupt and halt registers.
// Serves single-cycle register reads and writes.
// Produces edge-detected match pulses and the aggregated interrupt.
module timer_regfile_mc #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              r_en_i,
   input  logic              w_en_i,
   input  logic [11:0]       addr_i,
   input  logic [31:0]       wdata_i,
   input  logic [3:0]        byte_en_i,
   input  logic [CNT_W-1:0]  counter_i,
   input  logic              halt_ack_i,
   output logic [31:0]       rdata_o,
   output logic              error_o,
   output logic              timer_en_o,
   output logic              div_en_o,
   output logic [3:0]        div_val_o,
   output logic              halt_req_o,
   output logic              tdr0_wr_select_o,
   output logic              tdr1_wr_select_o,
   output logic [31:0]       tdr0_value_o,
   output logic [31:0]       tdr1_value_o,
   output logic [NUM_CH-1:0] match_o,
   output logic              irq_o
);

   localparam logic [11:0] A_TCR    = 12'h000;
   localparam logic [11:0] A_TDR0   = 12'h004;
   localparam logic [11:0] A_TDR1   = 12'h008;
   localparam logic [11:0] A_TIER   = 12'h014;
   localparam logic [11:0] A_TISR   = 12'h018;
   localparam logic [11:0] A_THCSR  = 12'h01C;
   localparam logic [11:0] A_TCMODE = 12'h020;

   logic              timer_en_q, timer_en_d, div_en_q, div_en_d;
   logic [3:0]        div_val_q, div_val_d;
   logic [31:0]       tdr0_q, tdr0_d, tdr1_q, tdr1_d;
   logic              tdr0_sel_q, tdr0_sel_d, tdr1_sel_q, tdr1_sel_d;
   logic [NUM_CH-1:0] tier_q, tier_d, tisr_q, tisr_d, tcmode_q, tcmode_d;
   logic [NUM_CH-1:0] eq_q, eq, tisr_clr;
   logic              halt_req_q, halt_req_d, halt_ack_q;
   logic [CNT_W-1:0]  cmp_q [NUM_CH];
   logic [CNT_W-1:0]  cmp_d [NUM_CH];
   logic [CNT_W-1:0]  per_q [NUM_CH];
   logic [CNT_W-1:0]  per_d [NUM_CH];
   logic [63:0]       cmp64 [NUM_CH];
   logic [63:0]       per64 [NUM_CH];
   logic [63:0]       cnt64, cmp_w, per_w;
   logic              cmp_wr;

   logic sel_tcr, sel_tdr0, sel_tdr1, sel_tier, sel_tisr, sel_thcsr, sel_tcmode;
   logic sel_ch, mapped, div_bad, div_lock, tcr_err;
   logic [3:0]  ch_idx;
   logic [1:0]  ch_off;
   logic [31:0] rd_val;

   function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
      end
      return res;
   endfunction

   // Zero-extended 64-bit views so HI halves read 0 when the counter is 32 bits.
   always_comb begin
      cnt64 = 64'(counter_i);
      for (int k = 0; k < NUM_CH; k++) begin
         cmp64[k] = 64'(cmp_q[k]);
         per64[k] = 64'(per_q[k]);
      end
   end

   // Address decode.
   always_comb begin
      ch_idx     = addr_i[7:4];
      ch_off     = addr_i[3:2];
      sel_tcr    = (addr_i == A_TCR);
      sel_tdr0   = (addr_i == A_TDR0);
      sel_tdr1   = (addr_i == A_TDR1);
      sel_tier   = (addr_i == A_TIER);
      sel_tisr   = (addr_i == A_TISR);
      sel_thcsr  = (addr_i == A_THCSR);
      sel_tcmode = (addr_i == A_TCMODE);
      sel_ch     = (addr_i[11:8] == 4'h1) && (addr_i[1:0] == 2'b00) &&
                   ({28'd0, ch_idx} < 32'(NUM_CH));
      mapped     = sel_tcr || sel_tdr0 || sel_tdr1 || sel_tier || sel_tisr ||
                   sel_thcsr || sel_tcmode || sel_ch;
   end

   // A divider change is refused if it is out of range or the timer is running.
   assign div_bad  = byte_en_i[1] && (wdata_i[11:8] > 4'd8);
   assign div_lock = timer_en_q &&
                     ((byte_en_i[0] && (wdata_i[1] != div_en_q)) ||
                      (byte_en_i[1] && (wdata_i[11:8] != div_val_q)));
   assign tcr_err  = w_en_i && sel_tcr && (div_bad || div_lock);
   assign error_o  = ((r_en_i || w_en_i) && !mapped) || tcr_err;

   // Read mux; TDR reads return the live counter.
   always_comb begin
      rd_val = '0;
      if (sel_tcr)         rd_val = {20'd0, div_val_q, 6'd0, div_en_q, timer_en_q};
      else if (sel_tdr0)   rd_val = cnt64[31:0];
      else if (sel_tdr1)   rd_val = cnt64[63:32];
      else if (sel_tier)   rd_val = 32'(tier_q);
      else if (sel_tisr)   rd_val = 32'(tisr_q);
      else if (sel_thcsr)  rd_val = {30'd0, halt_ack_q, halt_req_q};
      else if (sel_tcmode) rd_val = 32'(tcmode_q);
      else if (sel_ch) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (ch_idx == 4'(k)) begin
               case (ch_off)
                  2'd0:    rd_val = cmp64[k][31:0];
                  2'd1:    rd_val = cmp64[k][63:32];
                  2'd2:    rd_val = per64[k][31:0];
                  default: rd_val = per64[k][63:32];
               endcase
            end
         end
      end
   end
   assign rdata_o = r_en_i ? rd_val : 32'd0;

   // Rising-edge match detection; suppressed while in reset.
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) eq[k] = (counter_i == cmp_q[k]);
      match_o = eq & ~eq_q & {NUM_CH{!rst_i}};
   end

   // Next state for the global registers; a new match outranks a W1C clear.
   always_comb begin
      timer_en_d = timer_en_q;
      div_en_d   = div_en_q;
      div_val_d  = div_val_q;
      tdr0_d     = tdr0_q;
      tdr1_d     = tdr1_q;
      tier_d     = tier_q;
      tcmode_d   = tcmode_q;
      halt_req_d = halt_req_q;
      tdr0_sel_d = w_en_i && sel_tdr0;
      tdr1_sel_d = w_en_i && sel_tdr1;
      tisr_clr   = (w_en_i && sel_tisr && byte_en_i[0]) ? wdata_i[NUM_CH-1:0] : '0;
      tisr_d     = (tisr_q & ~tisr_clr) | match_o;
      if (w_en_i) begin
         if (sel_tcr) begin
            if (byte_en_i[0]) timer_en_d = wdata_i[0];
            if (!div_bad && !div_lock) begin
               if (byte_en_i[0]) div_en_d  = wdata_i[1];
               if (byte_en_i[1]) div_val_d = wdata_i[11:8];
            end
         end
         if (sel_tdr0) tdr0_d = be_merge(tdr0_q, wdata_i, byte_en_i);
         if (sel_tdr1 && (CNT_W == 64)) tdr1_d = be_merge(tdr1_q, wdata_i, byte_en_i);
         if (sel_tier && byte_en_i[0])   tier_d     = wdata_i[NUM_CH-1:0];
         if (sel_tcmode && byte_en_i[0]) tcmode_d   = wdata_i[NUM_CH-1:0];
         if (sel_thcsr && byte_en_i[0])  halt_req_d = wdata_i[0];
      end
   end

   // Per-channel compare/period update; a software CMP write beats the periodic reload.
   always_comb begin
      cmp_w  = '0;
      per_w  = '0;
      cmp_wr = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         cmp_w  = cmp64[k];
         per_w  = per64[k];
         cmp_wr = 1'b0;
         if (w_en_i && sel_ch && (ch_idx == 4'(k))) begin
            case (ch_off)
               2'd0: begin
                  cmp_w[31:0] = be_merge(cmp64[k][31:0], wdata_i, byte_en_i);
                  cmp_wr      = 1'b1;
               end
               2'd1: begin
                  if (CNT_W == 64) begin
                     cmp_w[63:32] = be_merge(cmp64[k][63:32], wdata_i, byte_en_i);
                     cmp_wr       = 1'b1;
                  end
               end
               2'd2: per_w[31:0] = be_merge(per64[k][31:0], wdata_i, byte_en_i);
               default: begin
                  if (CNT_W == 64) per_w[63:32] = be_merge(per64[k][63:32], wdata_i, byte_en_i);
               end
            endcase
         end
         if (cmp_wr)
            cmp_d[k] = CNT_W'(cmp_w);
         else if (match_o[k] && tcmode_q[k] && (per_q[k] != '0))
            cmp_d[k] = cmp_q[k] + per_q[k];
         else
            cmp_d[k] = cmp_q[k];
         per_d[k] = CNT_W'(per_w);
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         timer_en_q <= 1'b0;
         div_en_q   <= 1'b0;
         div_val_q  <= 4'd1;
         tdr0_q     <= '0;
         tdr1_q     <= '0;
         tdr0_sel_q <= 1'b0;
         tdr1_sel_q <= 1'b0;
         tier_q     <= '0;
         tisr_q     <= '0;
         tcmode_q   <= '0;
         eq_q       <= '0;
         halt_req_q <= 1'b0;
         halt_ack_q <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            cmp_q[k] <= '1;
            per_q[k] <= '0;
         end
      end else begin
         timer_en_q <= timer_en_d;
         div_en_q   <= div_en_d;
         div_val_q  <= div_val_d;
         tdr0_q     <= tdr0_d;
         tdr1_q     <= tdr1_d;
         tdr0_sel_q <= tdr0_sel_d;
         tdr1_sel_q <= tdr1_sel_d;
         tier_q     <= tier_d;
         tisr_q     <= tisr_d;
         tcmode_q   <= tcmode_d;
         eq_q       <= eq;
         halt_req_q <= halt_req_d;
         halt_ack_q <= halt_ack_i;
         cmp_q      <= cmp_d;
         per_q      <= per_d;
      end
   end

   assign timer_en_o       = timer_en_q;
   assign div_en_o         = div_en_q;
   assign div_val_o        = div_val_q;
   assign halt_req_o       = halt_req_q;
   assign tdr0_wr_select_o = tdr0_sel_q;
   assign tdr1_wr_select_o = tdr1_sel_q;
   assign tdr0_value_o     = tdr0_q;
   assign tdr1_value_o     = tdr1_q;
   assign irq_o            = |(tisr_q & tier_q);

endmodule

// File: tb/tb_timer_regfile_mc.sv
// Directed bench for timer_regfile_mc (NUM_CH=4, CNT_W=64).
module tb_timer_regfile_mc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        r_en = 1'b0, w_en = 1'b0;
   logic [11:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  byte_en = '0;
   logic [63:0] cnt = '1;
   logic        halt_ack = 1'b0;
   logic [31:0] rdata, tdr0_value, tdr1_value;
   logic        error, timer_en, div_en, halt_req, tdr0_sel, tdr1_sel, irq;
   logic [3:0]  div_val, match;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] rv;
   logic        ev;
   int          pulses;
   int          mv [8];

   timer_regfile_mc #(.NUM_CH(4), .CNT_W(64)) dut (
      .clk_i(clk), .rst_i(rst), .r_en_i(r_en), .w_en_i(w_en), .addr_i(addr),
      .wdata_i(wdata), .byte_en_i(byte_en), .counter_i(cnt), .halt_ack_i(halt_ack),
      .rdata_o(rdata), .error_o(error), .timer_en_o(timer_en), .div_en_o(div_en),
      .div_val_o(div_val), .halt_req_o(halt_req), .tdr0_wr_select_o(tdr0_sel),
      .tdr1_wr_select_o(tdr1_sel), .tdr0_value_o(tdr0_value), .tdr1_value_o(tdr1_value),
      .match_o(match), .irq_o(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be,
                     output logic err);
      @(negedge clk);
      addr = a; wdata = d; byte_en = be; w_en = 1'b1;
      #1 err = error;
      @(posedge clk);
      #1 w_en = 1'b0; byte_en = 4'h0;
   endtask

   task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic err);
      @(negedge clk);
      addr = a; r_en = 1'b1;
      #1 d = rdata; err = error;
      @(posedge clk);
      #1 r_en = 1'b0;
   endtask

   // Hold the counter at v for n cycles, recording match[ch] pulses.
   task automatic hold(input logic [63:0] v, input int n, input int ch);
      @(negedge clk);
      cnt = v;
      for (int c = 0; c < n; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (match[ch]) begin
            if (pulses < 8) mv[pulses] = int'(v[31:0]);
            pulses++;
         end
      end
   endtask

   initial begin
      // Reset with the counter equal to the reset CMP value: no match allowed.
      repeat (2) @(negedge clk);
      chk("match_in_reset", 64'(match), 64'h0);
      cnt = 64'h0;
      rst = 1'b0;
      rd(12'h000, rv, ev);  chk("rst_tcr", 64'(rv), 64'h100);  chk("rst_tcr_err", 64'(ev), 64'h0);
      rd(12'h100, rv, ev);  chk("rst_cmp0_lo", 64'(rv), 64'hFFFF_FFFF);
      rd(12'h018, rv, ev);  chk("rst_tisr", 64'(rv), 64'h0);
      chk("rst_irq", 64'(irq), 64'h0);
      chk("rst_div_val", 64'(div_val), 64'h1);

      // TDR write with byte lanes, select pulse, live counter readback.
      cnt = 64'h1234_5678_9ABC_DEF0;
      wr(12'h004, 32'hDEAD_BEEF, 4'b0011, ev);
      chk("tdr0_sel_pulse", 64'(tdr0_sel), 64'h1);
      chk("tdr0_value", 64'(tdr0_value), 64'h0000_BEEF);
      @(posedge clk); #1;
      chk("tdr0_sel_clear", 64'(tdr0_sel), 64'h0);
      rd(12'h004, rv, ev);  chk("tdr0_live", 64'(rv), 64'h9ABC_DEF0);
      rd(12'h008, rv, ev);  chk("tdr1_live", 64'(rv), 64'h1234_5678);

      // One-shot channel 0 at 0x10.
      cnt = 64'h0E;
      wr(12'h014, 32'h1, 4'h1, ev);
      wr(12'h100, 32'h10, 4'hF, ev);
      wr(12'h104, 32'h0, 4'hF, ev);
      pulses = 0;
      for (int v = 'h0E; v <= 'h14; v++) begin
         hold(64'(v), 1, 0);
         if (v == 'h10) chk("irq_before_edge", 64'(irq), 64'h0);
         if (v == 'h11) chk("irq_after_match", 64'(irq), 64'h1);
      end
      chk("oneshot_pulses", 64'(pulses), 64'd1);
      chk("oneshot_at", 64'(mv[0]), 64'h10);
      wr(12'h018, 32'h1, 4'h1, ev);
      chk("irq_after_w1c", 64'(irq), 64'h0);
      pulses = 0;
      hold(64'h14, 3, 0);
      chk("oneshot_no_more", 64'(pulses), 64'd0);

      // Periodic channel 1, counter held 3 cycles per value.
      wr(12'h020, 32'h2, 4'h1, ev);
      wr(12'h110, 32'h20, 4'hF, ev);
      wr(12'h114, 32'h0, 4'hF, ev);
      wr(12'h118, 32'h20, 4'hF, ev);
      pulses = 0;
      for (int v = 'h1E; v <= 'h22; v++) hold(64'(v), 3, 1);
      rd(12'h110, rv, ev);  chk("per_cmp1_after1", 64'(rv), 64'h40);
      for (int v = 'h23; v <= 'h62; v++) hold(64'(v), 3, 1);
      chk("per_pulses", 64'(pulses), 64'd3);
      chk("per_at0", 64'(mv[0]), 64'h20);
      chk("per_at1", 64'(mv[1]), 64'h40);
      chk("per_at2", 64'(mv[2]), 64'h60);
      rd(12'h110, rv, ev);  chk("per_cmp1_final", 64'(rv), 64'h80);
      rd(12'h018, rv, ev);  chk("per_tisr", 64'(rv), 64'h2);

      // PER1 = 0 behaves as one-shot; a held counter gives one pulse.
      wr(12'h118, 32'h0, 4'hF, ev);
      pulses = 0;
      hold(64'h80, 3, 1);
      chk("per0_pulses", 64'(pulses), 64'd1);
      rd(12'h110, rv, ev);  chk("per0_no_reload", 64'(rv), 64'h80);

      // Wrap-around reload on channel 2.
      wr(12'h020, 32'h6, 4'h1, ev);
      wr(12'h120, 32'hFFFF_FFF0, 4'hF, ev);
      wr(12'h124, 32'hFFFF_FFFF, 4'hF, ev);
      wr(12'h128, 32'h20, 4'hF, ev);
      pulses = 0;
      hold(64'hFFFF_FFFF_FFFF_FFF0, 1, 2);
      chk("wrap_match", 64'(pulses), 64'd1);
      rd(12'h120, rv, ev);  chk("wrap_cmp2_lo", 64'(rv), 64'h10);
      rd(12'h124, rv, ev);  chk("wrap_cmp2_hi", 64'(rv), 64'h0);

      // W1C of TISR[0] in the same cycle as match[0]: set wins.
      hold(64'h05, 1, 0);
      @(negedge clk);
      cnt = 64'h10; addr = 12'h018; wdata = 32'h1; byte_en = 4'h1; w_en = 1'b1;
      #1 chk("conflict_match0", 64'(match[0]), 64'h1);
      @(posedge clk); #1 w_en = 1'b0; byte_en = 4'h0;
      rd(12'h018, rv, ev);  chk("conflict_tisr", 64'(rv), 64'h7);

      // CMP0 write in the same cycle as a reload: written value kept.
      wr(12'h018, 32'h7, 4'h1, ev);
      wr(12'h020, 32'h7, 4'h1, ev);
      wr(12'h108, 32'h100, 4'hF, ev);
      hold(64'h00, 2, 0);
      @(negedge clk);
      cnt = 64'h10; addr = 12'h100; wdata = 32'h55; byte_en = 4'hF; w_en = 1'b1;
      @(posedge clk); #1 w_en = 1'b0; byte_en = 4'h0;
      rd(12'h100, rv, ev);  chk("conflict_cmp0", 64'(rv), 64'h55);
      rd(12'h018, rv, ev);  chk("conflict_tisr0", 64'(rv), 64'h1);

      // TCR divider protection.
      wr(12'h000, 32'h0000_0001, 4'hF, ev);  chk("tcr_en_err", 64'(ev), 64'h0);
      chk("tcr_en", 64'(timer_en), 64'h1);
      chk("tcr_div0", 64'(div_val), 64'h0);
      wr(12'h000, 32'h0000_0301, 4'hF, ev);  chk("tcr_lock_err", 64'(ev), 64'h1);
      chk("tcr_lock_hold", 64'(div_val), 64'h0);
      wr(12'h000, 32'h0000_0000, 4'h1, ev);  chk("tcr_dis_err", 64'(ev), 64'h0);
      chk("tcr_dis", 64'(timer_en), 64'h0);
      wr(12'h000, 32'h0000_0900, 4'h2, ev);  chk("tcr_div9_err", 64'(ev), 64'h1);
      chk("tcr_div9_hold", 64'(div_val), 64'h0);
      wr(12'h000, 32'h0000_0800, 4'h2, ev);  chk("tcr_div8_err", 64'(ev), 64'h0);
      chk("tcr_div8", 64'(div_val), 64'h8);
      wr(12'h000, 32'h0000_0903, 4'h3, ev);  chk("tcr_mix_err", 64'(ev), 64'h1);
      chk("tcr_mix_en", 64'(timer_en), 64'h1);
      chk("tcr_mix_diven", 64'(div_en), 64'h0);
      chk("tcr_mix_div", 64'(div_val), 64'h8);

      // Unmapped accesses.
      rd(12'h140, rv, ev);  chk("unmap_ch4_err", 64'(ev), 64'h1);  chk("unmap_ch4_rd", 64'(rv), 64'h0);
      rd(12'h00C, rv, ev);  chk("unmap_gap_err", 64'(ev), 64'h1);
      wr(12'h140, 32'hFFFF_FFFF, 4'hF, ev);  chk("unmap_wr_err", 64'(ev), 64'h1);
      rd(12'h130, rv, ev);  chk("ch3_ok_err", 64'(ev), 64'h0);  chk("ch3_cmp", 64'(rv), 64'hFFFF_FFFF);

      // Read and write together: read shows the old value.
      @(negedge clk);
      addr = 12'h014; wdata = 32'hF; byte_en = 4'h1; w_en = 1'b1; r_en = 1'b1;
      #1 chk("rw_pre_write", 64'(rdata), 64'h1);
      @(posedge clk); #1 w_en = 1'b0; r_en = 1'b0; byte_en = 4'h0;
      rd(12'h014, rv, ev);  chk("tier_after_rw", 64'(rv), 64'hF);
      chk("irq_enabled", 64'(irq), 64'h1);
      @(negedge clk); addr = 12'h000;
      #1 chk("rdata_idle", 64'(rdata), 64'h0);

      // Halt handshake.
      halt_ack = 1'b1;
      rd(12'h01C, rv, ev);  chk("thcsr_ack", 64'(rv), 64'h2);
      wr(12'h01C, 32'h1, 4'h1, ev);
      chk("halt_req", 64'(halt_req), 64'h1);
      rd(12'h01C, rv, ev);  chk("thcsr_both", 64'(rv), 64'h3);

      // Reset mid-operation.
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      rd(12'h000, rv, ev);  chk("rst2_tcr", 64'(rv), 64'h100);
      rd(12'h014, rv, ev);  chk("rst2_tier", 64'(rv), 64'h0);
      rd(12'h100, rv, ev);  chk("rst2_cmp0", 64'(rv), 64'hFFFF_FFFF);
      chk("rst2_irq", 64'(irq), 64'h0);
      chk("rst2_halt", 64'(halt_req), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
